shared_reg_arbiter: RTL

//  Round-robin arbiter giving NUM_REQ requesters exclusive write access to one

---
 rtl/shared_reg_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin arbiter that gives one requester at a time write access to a
// single shared register. An owner can extend its ownership cycle by cycle
// with lock. A down-counter cuts a lock that runs too long, and that cut is
// flagged on timeout_err.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no owner; arbitrate among req from rr_ptr, wrapping round
// ST_OWNED   | gnt = one-hot(owner); owner's lane written while req[owner]
// ST_RELEASE | gnt low; rr_ptr moves past the owner; timeout_err if cut
// (2'b11)    | unused; behaves as ST_IDLE with every output inactive
module shared_reg_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 2,
  parameter  int TIMEOUT = 15,
  localparam int OW      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         reg_q,
  output logic [OW-1:0]             owner,
  output logic                      busy,
  output logic                      timeout_err
);

  // Lock-extension budget counter width (holds 0..TIMEOUT)
  localparam int CW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_OWNED   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [DATA_W-1:0]   r_reg_q;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_lock_left;
  logic                r_timeout_err;

  logic [DATA_W-1:0]   w_lane [NUM_REQ];
  logic                w_any_req;
  logic [OW-1:0]       w_winner;
  logic [NUM_REQ-1:0]  w_win_onehot;
  logic                w_own_req;
  logic                w_own_lock;
  logic [DATA_W-1:0]   w_own_lane;
  logic [OW-1:0]       w_rr_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_lane[g] = wr_data[g*DATA_W +: DATA_W];
  end

  assign w_own_req    = req[r_owner];
  assign w_own_lock   = lock[r_owner];
  assign w_own_lane   = w_lane[r_owner];
  assign w_win_onehot = NUM_REQ'(1) << w_winner;
  assign w_rr_next    = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // Round-robin search: first requester at or above rr_ptr, wrapping at NUM_REQ-1
  always_comb begin : p_rr_search
    logic [OW-1:0] w_idx;
    w_any_req = 1'b0;
    w_winner  = '0;
    w_idx     = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any_req && req[w_idx]) begin
        w_any_req = 1'b1;
        w_winner  = w_idx;
      end
      w_idx = (w_idx == OW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  // Ownership FSM with registered grant, shared register and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_reg_q       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_lock_left   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_gnt <= '0;
          if (w_any_req) begin
            r_owner     <= w_winner;
            r_lock_left <= CW'(TIMEOUT);
            r_gnt       <= w_win_onehot;
            r_state     <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (w_own_req) begin
            r_reg_q <= w_own_lane;
          end
          if (w_own_req && w_own_lock && (r_lock_left != '0)) begin
            r_lock_left <= r_lock_left - 1'b1;
          end else begin
            // A cut with req and lock still high is a forced release
            r_timeout_err <= w_own_req && w_own_lock;
            r_gnt         <= '0;
            r_state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_gnt    <= '0;
          r_rr_ptr <= w_rr_next;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are gated by state so the unused encoding presents as idle
  assign gnt         = r_gnt & {NUM_REQ{r_state == ST_OWNED}};
  assign reg_q       = r_reg_q;
  assign owner       = r_owner;
  assign busy        = (r_state == ST_OWNED) || (r_state == ST_RELEASE);
  assign timeout_err = r_timeout_err && (r_state == ST_RELEASE);

endmodule
